// File: rtl/vector_dot_stream_pkg.sv
// Shared float32 definitions and the float multiply/add units used by the dot-product datapath.
// Arithmetic: round-to-nearest-even, denormal inputs/outputs flushed to signed zero, canonical qNaN.
`ifndef VECTOR_DOT_STREAM_PKG_SV
`define VECTOR_DOT_STREAM_PKG_SV

`define FP_LANE(vec, i) vec[32*(i) +: 32]

package vector_dot_stream_pkg;

  localparam int unsigned FP_WIDTH    = 32;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == FP_EXP_MAX) && (f[22:0] != 23'h0);
  endfunction

  // Round a normalised fraction with guard/sticky, then saturate to inf or flush to zero.
  function automatic logic [31:0] fp_round_pack(input logic s, input logic signed [9:0] e,
                                                input logic [22:0] frac, input logic g,
                                                input logic st);
    logic [23:0]       fr;
    logic signed [9:0] er;
    fr = {1'b0, frac} + 24'(g & (st | frac[0]));
    er = fr[23] ? e + 10'sd1 : e;
    if (er >= 10'sd255) return {s, FP_EXP_MAX, 23'h0};
    if (er <= 10'sd0)   return {s, 31'h0};
    return {s, er[7:0], fr[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic              za, zb, ia, ib;
    logic [47:0]       p;
    logic signed [9:0] e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == FP_EXP_MAX);
    ib = (b[30:23] == FP_EXP_MAX);
    if (is_nan(a) || is_nan(b) || (ia && zb) || (ib && za)) return FP_QNAN;
    if (ia || ib) return {s, FP_EXP_MAX, 23'h0};
    if (za || zb) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) return fp_round_pack(s, e + 10'sd1, p[46:24], p[23], |p[22:0]);
    return fp_round_pack(s, e, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d8;
    logic [5:0]        d;
    logic [49:0]       ys;
    logic [26:0]       mx, my, n;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic              za, zb;
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    if (is_nan(a) || is_nan(b)) return FP_QNAN;
    if ((a[30:23] == FP_EXP_MAX) && (b[30:23] == FP_EXP_MAX))
      return (a[31] != b[31]) ? FP_QNAN : a;
    if (a[30:23] == FP_EXP_MAX) return a;
    if (b[30:23] == FP_EXP_MAX) return b;
    if (za && zb) return {a[31] & b[31], 31'h0};
    if (za) return b;
    if (zb) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    // Align the smaller operand keeping guard, round and a sticky bit.
    d8 = x[30:23] - y[30:23];
    d  = (d8 > 8'd49) ? 6'd49 : d8[5:0];
    ys = {1'b1, y[22:0], 26'h0} >> d;
    my = {ys[49:24], |ys[23:0]};
    mx = {1'b1, x[22:0], 3'b000};
    e  = $signed({2'b00, x[30:23]});
    lz = 5'd0;
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        n = {sum[27:2], sum[1] | sum[0]};
        e = e + 10'sd1;
      end else begin
        n = sum[26:0];
      end
    end else begin
      n = mx - my;
      if (n == 27'h0) return FP_POS_ZERO;
      for (int i = 0; i < 27; i++) begin
        if (n[i]) lz = 5'(26 - i);
      end
      n = n << lz;
      e = e - $signed({5'b00000, lz});
    end
    return fp_round_pack(x[31], e, n[25:3], n[2], n[1] | n[0]);
  endfunction

endpackage

`endif

// File: rtl/vector_dot_stream_dot_lane_tree.sv
// Combinational per-beat datapath: LANES float multiplies, masking, and a strictly ordered add chain.
module dot_lane_tree
  import vector_dot_stream_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic [FP_WIDTH*LANES-1:0] a_i,
  input  logic [FP_WIDTH*LANES-1:0] b_i,
  input  logic [LANES-1:0]          mask_i,
  output logic [FP_WIDTH-1:0]       beat_sum_c,
  output logic                      lane_nan_c
);

  logic [FP_WIDTH-1:0] prod;

  // Sum is ((p0+p1)+p2)+... so results are reproducible bit-for-bit.
  always_comb begin
    beat_sum_c = FP_POS_ZERO;
    lane_nan_c = 1'b0;
    prod       = FP_POS_ZERO;
    for (int i = 0; i < int'(LANES); i++) begin
      prod       = mask_i[i] ? FP_POS_ZERO : fp_mul(`FP_LANE(a_i, i), `FP_LANE(b_i, i));
      lane_nan_c = lane_nan_c | is_nan(prod);
      beat_sum_c = (i == 0) ? prod : fp_add(beat_sum_c, prod);
    end
    lane_nan_c = lane_nan_c | is_nan(beat_sum_c);
  end

endmodule

// File: rtl/vector_dot_stream.sv
// Streaming float32 dot-product engine: accumulates ceil(VLEN/LANES) beats, emits one result per vector.
// Define VECTOR_DOT_RELU_EN to clamp negative (non-NaN) results to +0.0 when latched.
module vector_dot_stream
  import vector_dot_stream_pkg::*;
#(
  parameter int unsigned VLEN  = 5,
  parameter int unsigned LANES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FP_WIDTH*LANES-1:0] a_in,
  input  logic [FP_WIDTH*LANES-1:0] b_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FP_WIDTH-1:0]       result,
  output logic                      nan_seen
);

  localparam int unsigned BEATS = (VLEN + LANES - 1) / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [FP_WIDTH-1:0] acc_q;
  logic [FP_WIDTH-1:0] result_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                nan_seen_q;

  logic [LANES-1:0]    lane_mask;
  logic [FP_WIDTH-1:0] beat_sum;
  logic                lane_nan;
  logic [FP_WIDTH-1:0] acc_d;
  logic [FP_WIDTH-1:0] result_d;
  logic                nan_d;
  logic                last_beat;

  // Lanes past the end of the vector contribute +0.0 whatever is on the bus.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_mask[i] = (int'(beat_cnt_q) * int'(LANES) + i) >= int'(VLEN);
    end
  end

  dot_lane_tree #(
    .LANES(LANES)
  ) u_tree (
    .a_i       (a_in),
    .b_i       (b_in),
    .mask_i    (lane_mask),
    .beat_sum_c(beat_sum),
    .lane_nan_c(lane_nan)
  );

  always_comb begin
    acc_d     = fp_add(acc_q, beat_sum);
    last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    nan_d     = ((beat_cnt_q == '0) ? 1'b0 : nan_seen_q) | lane_nan | is_nan(acc_d);
`ifdef VECTOR_DOT_RELU_EN
    result_d  = (acc_d[31] && !is_nan(acc_d)) ? FP_POS_ZERO : acc_d;
`else
    result_d  = acc_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      beat_cnt_q  <= '0;
      acc_q       <= FP_POS_ZERO;
      result_q    <= FP_POS_ZERO;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      nan_seen_q  <= 1'b0;
    end else if (state_q == ST_ACC) begin
      if (in_valid) begin
        nan_seen_q <= nan_d;
        if (last_beat) begin
          result_q    <= result_d;
          acc_q       <= FP_POS_ZERO;
          beat_cnt_q  <= '0;
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b0;
        end else begin
          acc_q      <= acc_d;
          beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
      end
    end else if (out_ready) begin
      state_q     <= ST_ACC;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign nan_seen  = nan_seen_q;

endmodule
